ir_frame_decoder: RTL
=====================

Name: ir_frame_decoder

Overview:
Pulse-distance (NEC-style) IR frame decoder. Measures mark/space run lengths of a synchronized input with an internal run-length timer, then sequences those lengths through a protocol FSM. Produces a NUM_BITS frame, or a one-cycle error pulse on any malformed frame. Sits between the input synchronizer and the command-handling logic.

Parameters:
NUM_BITS, 32, payload bits per frame
LEAD_MARK_MIN, 800_000, minimum leader mark length in cycles (100 MHz)
LEAD_MARK_MAX, 1_000_000, maximum leader mark length in cycles
LEAD_SPACE_MIN, 400_000, minimum leader space length in cycles
LEAD_SPACE_MAX, 500_000, maximum leader space length in cycles
BIT_MARK_MIN, 40_000, minimum bit/stop mark length in cycles
BIT_MARK_MAX, 70_000, maximum bit/stop mark length in cycles
ZERO_SPACE_MIN, 40_000, minimum space length for a 0 bit
ZERO_SPACE_MAX, 70_000, maximum space length for a 0 bit
ONE_SPACE_MIN, 140_000, minimum space length for a 1 bit
ONE_SPACE_MAX, 200_000, maximum space length for a 1 bit
TIMEOUT_CYCLES, 1_200_000, maximum live run length while busy

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-low reset
signal_in  input  1  synchronized line; 1 = mark
frame_out  output  NUM_BITS  last good frame; bit i = i-th received bit (LSB first)
frame_valid_out  output  1  one-cycle pulse when frame_out updates
error_out  output  1  one-cycle pulse on protocol or timeout error
busy_out  output  1  high while FSM is not in IDLE

Behaviour:
- Reset (rst_in=0, asynchronous): all outputs 0; FSM in IDLE; timer count 0; last level 0.
- Reset mid-frame: discard the partial frame; no error pulse; frame_out cleared.
- Run timer, registered:
  - On each clock, compare signal_in with last level.
  - On a difference: pulse run_done for one cycle; run_len = number of cycles the previous level was held; run_level = previous level; count restarts at 1.
  - Otherwise count increments, saturating at 2^32-1 (no wrap).
- All length window checks are inclusive: MIN ≤ run_len ≤ MAX.
- FSM acts only on run_done, except for the timeout rule:
  - IDLE: run_done with level 0 (a mark has begun) -> LEAD_MARK.
  - LEAD_MARK: run_done with level 1:
    - length in leader-mark window -> LEAD_SPACE.
    - otherwise -> error, IDLE.
  - LEAD_SPACE: run_done with level 0:
    - length in leader-space window -> BIT_MARK; clear bit_cnt and shift register.
    - otherwise -> error, IDLE.
  - BIT_MARK: run_done with level 1:
    - length in bit-mark window -> BIT_SPACE.
    - otherwise -> error, IDLE.
  - BIT_SPACE: run_done with level 0:
    - zero window -> store 0; one window -> store 1; store at position bit_cnt.
    - if bit_cnt = NUM_BITS-1 -> STOP_MARK; otherwise increment bit_cnt and -> BIT_MARK.
    - length in neither window -> error, IDLE.
  - STOP_MARK: run_done with level 1:
    - length in bit-mark window -> load frame_out, pulse frame_valid_out, IDLE.
    - otherwise -> error, IDLE.
- Timeout: in any non-IDLE state, live count > TIMEOUT_CYCLES -> error_out, IDLE. The timeout check takes priority over a same-cycle run_done.
- Latency: outputs pulse on the clock edge after run_done, i.e. two edges after the first sample of the new level.
- Exclusivity: error_out and frame_valid_out are never high together.
- frame_out holds its value until the next good frame.
- busy_out is registered and equals (state != IDLE).

Optional Feature:
REPEAT_CODE_EN:
- Defined: adds parameters REPEAT_SPACE_MIN=200_000 and REPEAT_SPACE_MAX=250_000, output port repeat_out (1 bit) and state REPEAT_STOP.
  - LEAD_SPACE with length in the repeat window -> REPEAT_STOP.
  - REPEAT_STOP: valid bit mark -> one-cycle repeat_out pulse, frame_out unchanged; invalid mark -> error.
- Undefined: no repeat_out port; a repeat-length leader space is an error.

Decomposition:
- Package ir_decode_pkg:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_STOP).
  - default timing constants.
  - RUN_W=32 counter width.
- Sub-module run_length_timer:
  - async active-low reset; edge detect plus saturating counter.
  - outputs run_done, run_level, run_len, live_count.

Test Plan:
- Nominal frame 0x00FF_A25D: 900k mark, 450k space, 56_250 marks, 56_250/168_750 spaces, stop mark -> exactly one frame_valid_out pulse, frame_out=0x00FF_A25D, error_out never high.
- Leader mark of 700_000 cycles -> error_out pulse two edges after the mark ends, busy_out low afterwards, frame_out unchanged.
- Line held low after bit 10 -> error_out when live count reaches 1_200_001, then IDLE.
- rst_in low for 3 cycles after 16 bits, then full frame 0x1234_5678 -> no error_out, single frame_valid_out, frame_out=0x1234_5678.
- One-space lengths of exactly 140_000 and 200_000 -> decoded as 1; a space of 200_001 -> error_out.
- Repeat sequence (900k mark, 225k space, 56k mark):
  - with REPEAT_CODE_EN -> repeat_out pulse, frame_out unchanged.
  - without -> error_out.

Source files
------------

// File: rtl/ir_decode_pkg.sv
// Shared state encoding, default 100 MHz timing windows and helpers for the
// NEC-style IR frame decoder.
package ir_decode_pkg;

    localparam int RUN_W = 32;

    localparam int unsigned DEF_LEAD_MARK_MIN    = 800_000;
    localparam int unsigned DEF_LEAD_MARK_MAX    = 1_000_000;
    localparam int unsigned DEF_LEAD_SPACE_MIN   = 400_000;
    localparam int unsigned DEF_LEAD_SPACE_MAX   = 500_000;
    localparam int unsigned DEF_BIT_MARK_MIN     = 40_000;
    localparam int unsigned DEF_BIT_MARK_MAX     = 70_000;
    localparam int unsigned DEF_ZERO_SPACE_MIN   = 40_000;
    localparam int unsigned DEF_ZERO_SPACE_MAX   = 70_000;
    localparam int unsigned DEF_ONE_SPACE_MIN    = 140_000;
    localparam int unsigned DEF_ONE_SPACE_MAX    = 200_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 1_200_000;
    localparam int unsigned DEF_REPEAT_SPACE_MIN = 200_000;
    localparam int unsigned DEF_REPEAT_SPACE_MAX = 250_000;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        REPEAT_STOP
    } ir_state_e;

    // Inclusive window test on a measured run length.
    function automatic logic in_win(input logic [RUN_W-1:0] len,
                                    input logic [RUN_W-1:0] lo,
                                    input logic [RUN_W-1:0] hi);
        return (len >= lo) && (len <= hi);
    endfunction

endpackage

// File: rtl/run_length_timer.sv
// Measures how long the line held each level; pulses run_done with the length
// and level of the run that just ended, and exposes the live run count.
module run_length_timer
    import ir_decode_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             signal_in,
    output logic             run_done,
    output logic             run_level,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] live_count
);

    logic             r_last;
    logic             r_done;
    logic             r_level;
    logic [RUN_W-1:0] r_len;
    logic [RUN_W-1:0] r_count;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_level <= 1'b0;
            r_len   <= '0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (signal_in != r_last) begin
                r_done  <= 1'b1;
                r_len   <= r_count;
                r_level <= r_last;
                r_count <= RUN_W'(1);
                r_last  <= signal_in;
            end else if (r_count != '1) begin
                // Saturate so a stuck line never wraps back into a window.
                r_count <= r_count + RUN_W'(1);
            end
        end
    end

    assign run_done   = r_done;
    assign run_level  = r_level;
    assign run_len    = r_len;
    assign live_count = r_count;

endmodule

// File: rtl/ir_frame_decoder.sv
// NEC-style pulse-distance IR frame decoder: run-length timer feeding a
// protocol FSM. Define REPEAT_CODE_EN to accept repeat codes (adds repeat_out).
module ir_frame_decoder
    import ir_decode_pkg::*;
#(
    parameter int          NUM_BITS       = 32,
    parameter int unsigned LEAD_MARK_MIN  = DEF_LEAD_MARK_MIN,
    parameter int unsigned LEAD_MARK_MAX  = DEF_LEAD_MARK_MAX,
    parameter int unsigned LEAD_SPACE_MIN = DEF_LEAD_SPACE_MIN,
    parameter int unsigned LEAD_SPACE_MAX = DEF_LEAD_SPACE_MAX,
    parameter int unsigned BIT_MARK_MIN   = DEF_BIT_MARK_MIN,
    parameter int unsigned BIT_MARK_MAX   = DEF_BIT_MARK_MAX,
    parameter int unsigned ZERO_SPACE_MIN = DEF_ZERO_SPACE_MIN,
    parameter int unsigned ZERO_SPACE_MAX = DEF_ZERO_SPACE_MAX,
    parameter int unsigned ONE_SPACE_MIN  = DEF_ONE_SPACE_MIN,
    parameter int unsigned ONE_SPACE_MAX  = DEF_ONE_SPACE_MAX,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef REPEAT_CODE_EN
    ,
    parameter int unsigned REPEAT_SPACE_MIN = DEF_REPEAT_SPACE_MIN,
    parameter int unsigned REPEAT_SPACE_MAX = DEF_REPEAT_SPACE_MAX
`endif
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                signal_in,
    output logic [NUM_BITS-1:0] frame_out,
    output logic                frame_valid_out,
    output logic                error_out,
    output logic                busy_out
`ifdef REPEAT_CODE_EN
    ,
    output logic                repeat_out
`endif
);

    localparam int              CNT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    ir_state_e           r_state, w_next;
    logic                r_busy, r_err, r_fv;
    logic [NUM_BITS-1:0] r_frame, r_shift;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                w_done, w_level;
    logic [RUN_W-1:0]    w_len, w_live;
    logic                w_err, w_fv, w_clr, w_store, w_bit;
`ifdef REPEAT_CODE_EN
    logic                r_rep, w_rep;
`endif

    run_length_timer u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .signal_in  (signal_in),
        .run_done   (w_done),
        .run_level  (w_level),
        .run_len    (w_len),
        .live_count (w_live)
    );

    always_comb begin
        w_next  = r_state;
        w_err   = 1'b0;
        w_fv    = 1'b0;
        w_clr   = 1'b0;
        w_store = 1'b0;
        w_bit   = 1'b0;
`ifdef REPEAT_CODE_EN
        w_rep   = 1'b0;
`endif
        // A run that overstays the timeout wins over any run_done this cycle.
        if (r_state != IDLE && w_live > TIMEOUT_CYCLES) begin
            w_next = IDLE;
            w_err  = 1'b1;
        end else begin
            case (r_state)
                IDLE: if (w_done && !w_level) w_next = LEAD_MARK;
                LEAD_MARK: if (w_done && w_level) begin
                    if (in_win(w_len, LEAD_MARK_MIN, LEAD_MARK_MAX)) w_next = LEAD_SPACE;
                    else begin w_next = IDLE; w_err = 1'b1; end
                end
                LEAD_SPACE: if (w_done && !w_level) begin
                    if (in_win(w_len, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        w_next = BIT_MARK;
                        w_clr  = 1'b1;
                    end
`ifdef REPEAT_CODE_EN
                    else if (in_win(w_len, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) w_next = REPEAT_STOP;
`endif
                    else begin w_next = IDLE; w_err = 1'b1; end
                end
                BIT_MARK: if (w_done && w_level) begin
                    if (in_win(w_len, BIT_MARK_MIN, BIT_MARK_MAX)) w_next = BIT_SPACE;
                    else begin w_next = IDLE; w_err = 1'b1; end
                end
                BIT_SPACE: if (w_done && !w_level) begin
                    if (in_win(w_len, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                        in_win(w_len, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        w_store = 1'b1;
                        w_bit   = in_win(w_len, ONE_SPACE_MIN, ONE_SPACE_MAX);
                        w_next  = (r_bit_cnt == LAST_BIT) ? STOP_MARK : BIT_MARK;
                    end else begin
                        w_next = IDLE;
                        w_err  = 1'b1;
                    end
                end
                STOP_MARK: if (w_done && w_level) begin
                    w_next = IDLE;
                    if (in_win(w_len, BIT_MARK_MIN, BIT_MARK_MAX)) w_fv = 1'b1;
                    else w_err = 1'b1;
                end
`ifdef REPEAT_CODE_EN
                REPEAT_STOP: if (w_done && w_level) begin
                    w_next = IDLE;
                    if (in_win(w_len, BIT_MARK_MIN, BIT_MARK_MAX)) w_rep = 1'b1;
                    else w_err = 1'b1;
                end
`endif
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_fv      <= 1'b0;
            r_frame   <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef REPEAT_CODE_EN
            r_rep     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_err   <= w_err;
            r_fv    <= w_fv;
`ifdef REPEAT_CODE_EN
            r_rep   <= w_rep;
`endif
            if (w_clr) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_store) begin
                r_shift[r_bit_cnt] <= w_bit;
                if (r_bit_cnt != LAST_BIT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_fv) r_frame <= r_shift;
        end
    end

    assign frame_out       = r_frame;
    assign frame_valid_out = r_fv;
    assign error_out       = r_err;
    assign busy_out        = r_busy;
`ifdef REPEAT_CODE_EN
    assign repeat_out      = r_rep;
`endif

endmodule
